// File: rtl/spi_led_cmd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_led_cmd_ctrl_pkg
// Purpose : Shared constants and FSM state encoding for the SPI LED command
//           sequencer. These are the LED address width, the brightness width,
//           the brightness ceiling and the command bit positions.
//           LED_ADDR_WIDTH / BRIGHTNESS_WIDTH may be overridden by defining
//           the matching macros before this file is compiled.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
`ifndef LED_ADDR_WIDTH
`define LED_ADDR_WIDTH 2
`endif
`ifndef BRIGHTNESS_WIDTH
`define BRIGHTNESS_WIDTH 8
`endif

package spi_led_cmd_ctrl_pkg;

  localparam int LED_ADDR_WIDTH   = `LED_ADDR_WIDTH;
  localparam int BRIGHTNESS_WIDTH = `BRIGHTNESS_WIDTH;
  localparam int BR_MAX_PCT       = 100;

  // Command byte layout: bit7 selects write (1) / read (0), low bits carry
  // the LED address, everything in between is reserved and must be zero.
  localparam int CMD_RW_BIT       = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_led_cmd_ctrl_regfile.sv
`default_nettype none
// ============================================================================
// Module  : spi_led_regfile
// Purpose : NUM_LEDS x BR_WIDTH brightness shadow registers. One synchronous
//           write port, one combinational read port, synchronous reset.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           we, wr_addr,
//           wr_data         - write strobe / index / value
//           rd_addr         - read index
//           rd_data         - stored value (0 for out-of-range index)
// Rev     : 1.0 - initial release
// ============================================================================
module spi_led_regfile
  import spi_led_cmd_ctrl_pkg::*;
#(
  parameter int NUM_LEDS   = 4,
  parameter int ADDR_WIDTH = LED_ADDR_WIDTH,
  parameter int BR_WIDTH   = BRIGHTNESS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BR_WIDTH-1:0]   wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [BR_WIDTH-1:0]   rd_data
);

  logic [BR_WIDTH-1:0] br [NUM_LEDS];

  // One register per LED, each with its own address decode.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_reg
    logic [BR_WIDTH-1:0] q;

    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (we && (wr_addr == ADDR_WIDTH'(i))) begin
        q <= wr_data;
      end
    end

    assign br[i] = q;
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < NUM_LEDS) begin
      rd_data = br[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_led_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : spi_led_cmd_ctrl
// Purpose : Command sequencer between the SPI slave byte engine and the LED
//           PWM stage. It parses two-byte frames (command, data), keeps the
//           brightness shadow registers, issues LED write strobes and
//           supplies MISO response bytes for reads.
//           Optional macro SPI_CTRL_BURST_EN enables burst transfers. Further
//           data bytes then target addr+k (mod NUM_LEDS) until cs_n rises.
// Ports   : sysclk, rst         - clock, synchronous active-high reset
//           cs_n                - synchronised chip select (high = boundary)
//           rx_valid, rx_byte   - received byte strobe / value
//           tx_byte, tx_load    - next MISO byte / one-cycle update strobe
//           o_led_addr,
//           o_led_br_lvl,
//           o_led_we            - LED write index / level / strobe
//           o_frame_err         - one-cycle malformed-frame pulse
//           o_err_cnt           - saturating frame-error count
// Rev     : 1.0 - initial release
// ============================================================================
module spi_led_cmd_ctrl
  import spi_led_cmd_ctrl_pkg::*;
#(
  parameter int NUM_LEDS   = 4,
  parameter int ADDR_WIDTH = LED_ADDR_WIDTH,
  parameter int BR_WIDTH   = BRIGHTNESS_WIDTH,
  parameter int BR_MAX     = BR_MAX_PCT
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  cs_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic [7:0]            tx_byte,
  output logic                  tx_load,
  output logic [ADDR_WIDTH-1:0] o_led_addr,
  output logic [BR_WIDTH-1:0]   o_led_br_lvl,
  output logic                  o_led_we,
  output logic                  o_frame_err,
  output logic [7:0]            o_err_cnt
);

  localparam logic [7:0] BR_MAX_B = 8'(BR_MAX);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;

  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_bad;
  logic [7:0]            clamped8;
  logic [BR_WIDTH-1:0]   wr_data;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [BR_WIDTH-1:0]   rd_data;

`ifdef SPI_CTRL_BURST_EN
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (int'(a) >= NUM_LEDS - 1) begin
      return '0;
    end
    return a + ADDR_WIDTH'(1);
  endfunction
`endif

  // Command decode works directly on the incoming byte so the read data is
  // available in the same cycle the command is accepted.
  assign cmd_addr = rx_byte[ADDR_WIDTH-1:0];
  assign cmd_bad  = (rx_byte[6:ADDR_WIDTH] != '0) || (int'(cmd_addr) >= NUM_LEDS);

  // Unsigned clamp. Stored values are already clamped, so reads return them.
  assign clamped8 = (rx_byte > BR_MAX_B) ? BR_MAX_B : rx_byte;
  assign wr_data  = BR_WIDTH'(clamped8);

  // The shadow register commits on the same edge that raises o_led_we.
  assign rf_we    = (state == ST_WR_DATA) && rx_valid;

  always_comb begin
    rd_addr = cmd_addr;
`ifdef SPI_CTRL_BURST_EN
    if (state == ST_RD_DATA) begin
      rd_addr = next_addr(cur_addr);
    end
`endif
  end

  spi_led_regfile #(
    .NUM_LEDS   (NUM_LEDS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BR_WIDTH   (BR_WIDTH)
  ) u_regfile (
    .clk     (sysclk),
    .rst     (rst),
    .we      (rf_we),
    .wr_addr (cur_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cur_addr     <= '0;
      tx_byte      <= 8'h00;
      tx_load      <= 1'b0;
      o_led_addr   <= '0;
      o_led_br_lvl <= '0;
      o_led_we     <= 1'b0;
      o_frame_err  <= 1'b0;
      o_err_cnt    <= 8'h00;
    end else begin
      tx_load     <= 1'b0;
      o_led_we    <= 1'b0;
      o_frame_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          tx_byte <= 8'h00;
          if (!cs_n) begin
            state <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (rx_valid) begin
            if (cmd_bad) begin
              o_frame_err <= 1'b1;
              if (o_err_cnt != 8'hFF) begin
                o_err_cnt <= o_err_cnt + 8'd1;
              end
              state <= ST_DRAIN;
            end else if (rx_byte[CMD_RW_BIT]) begin
              cur_addr <= cmd_addr;
              state    <= ST_WR_DATA;
            end else begin
              cur_addr <= cmd_addr;
              tx_byte  <= 8'(rd_data);
              tx_load  <= 1'b1;
              state    <= ST_RD_DATA;
            end
          end
        end

        ST_WR_DATA: begin
          if (rx_valid) begin
            o_led_we     <= 1'b1;
            o_led_addr   <= cur_addr;
            o_led_br_lvl <= wr_data;
`ifdef SPI_CTRL_BURST_EN
            cur_addr     <= next_addr(cur_addr);
`else
            state        <= ST_DRAIN;
`endif
          end
        end

        ST_RD_DATA: begin
          if (rx_valid) begin
            tx_load  <= 1'b1;
`ifdef SPI_CTRL_BURST_EN
            tx_byte  <= 8'(rd_data);
            cur_addr <= next_addr(cur_addr);
`else
            tx_byte  <= 8'h00;
            state    <= ST_DRAIN;
`endif
          end
        end

        ST_DRAIN: begin
          tx_byte <= 8'h00;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Frame boundary overrides the next state. A byte arriving together
      // with cs_n high has already been handled above. The MISO byte is then
      // cleared in IDLE on the following cycle.
      if ((state != ST_IDLE) && cs_n) begin
        state <= ST_IDLE;
        if (!rx_valid) begin
          tx_byte <= 8'h00;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_led_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_led_cmd_ctrl
// Purpose : Scoreboard bench for spi_led_cmd_ctrl. Stimulus pushes expected
//           LED writes, MISO loads and error counts into queues. A monitor
//           pops them whenever the DUT strobes an output. Honours
//           SPI_CTRL_BURST_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_spi_led_cmd_ctrl;

  localparam int NUM_LEDS = 4;
  localparam int BR_MAX   = 100;
`ifdef SPI_CTRL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic [1:0] o_led_addr;
  logic [7:0] o_led_br_lvl;
  logic       o_led_we;
  logic       o_frame_err;
  logic [7:0] o_err_cnt;

  spi_led_cmd_ctrl dut (
    .sysclk       (sysclk),
    .rst          (rst),
    .cs_n         (cs_n),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .tx_byte      (tx_byte),
    .tx_load      (tx_load),
    .o_led_addr   (o_led_addr),
    .o_led_br_lvl (o_led_br_lvl),
    .o_led_we     (o_led_we),
    .o_frame_err  (o_frame_err),
    .o_err_cnt    (o_err_cnt)
  );

  always #4 sysclk = ~sysclk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int addr;
    int br;
  } wr_t;

  wr_t wr_q[$];
  int  tx_q[$];
  int  err_q[$];
  wr_t wr_e;
  int  exp_i;

  // Reference state: what the LEDs should hold and how many errors so far.
  int br_model[NUM_LEDS];
  int err_model = 0;
  int last_addr = 0;
  int last_br   = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    checks++;
    failures++;
    $display("FAIL %s: strobe with no expectation, value=%0d", name, act);
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge sysclk) begin
    if (!rst) begin
      if (o_led_we) begin
        if (wr_q.size() == 0) begin
          unexpected("unexpected_led_we", o_led_br_lvl);
        end else begin
          wr_e = wr_q.pop_front();
          check("we_addr", o_led_addr, wr_e.addr);
          check("we_br", o_led_br_lvl, wr_e.br);
        end
      end
      if (tx_load) begin
        if (tx_q.size() == 0) begin
          unexpected("unexpected_tx_load", tx_byte);
        end else begin
          exp_i = tx_q.pop_front();
          check("tx_byte", tx_byte, exp_i);
        end
      end
      if (o_frame_err) begin
        if (err_q.size() == 0) begin
          unexpected("unexpected_frame_err", o_err_cnt);
        end else begin
          exp_i = err_q.pop_front();
          check("err_cnt", o_err_cnt, exp_i);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge sysclk);
    #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge sysclk);
    #1;
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(posedge sysclk);
  endtask

  // One complete frame. Expectations come from the frame rules, not the FSM.
  task automatic frame(input logic [7:0] cmd, input int nd,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] d [4];
    int  a, wa, v;
    bit  bad;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    a    = int'(cmd[1:0]);
    bad  = (cmd[6:2] != 5'd0) || (a >= NUM_LEDS);

    @(posedge sysclk);
    #1 cs_n = 1'b0;
    @(posedge sysclk);

    if (bad) begin
      if (err_model < 255) err_model++;
      err_q.push_back(err_model);
    end else if (!cmd[7]) begin
      tx_q.push_back(br_model[a]);
    end
    send_byte(cmd);

    for (int k = 0; k < nd; k++) begin
      if (!bad) begin
        if (cmd[7]) begin
          if (BURST || k == 0) begin
            wa = (a + k) % NUM_LEDS;
            v  = (int'(d[k]) > BR_MAX) ? BR_MAX : int'(d[k]);
            br_model[wa] = v;
            wr_q.push_back('{wa, v});
            last_addr = wa;
            last_br   = v;
          end
        end else begin
          if (BURST) tx_q.push_back(br_model[(a + k + 1) % NUM_LEDS]);
          else if (k == 0) tx_q.push_back(0);
        end
      end
      send_byte(d[k]);
    end

    @(posedge sysclk);
    #1 cs_n = 1'b1;
    repeat (2) @(posedge sysclk);
    #1;
    check("idle_tx_byte", tx_byte, 0);
    check("hold_led_addr", o_led_addr, last_addr);
    check("hold_led_br", o_led_br_lvl, last_br);
  endtask

  logic [7:0] rc;
  int         kind;

  initial begin
    for (int i = 0; i < NUM_LEDS; i++) br_model[i] = 0;

    repeat (3) @(posedge sysclk);
    #1 rst = 1'b0;
    @(posedge sysclk);
    #1;
    check("rst_tx_byte", tx_byte, 0);
    check("rst_tx_load", tx_load, 0);
    check("rst_led_addr", o_led_addr, 0);
    check("rst_led_br", o_led_br_lvl, 0);
    check("rst_led_we", o_led_we, 0);
    check("rst_frame_err", o_frame_err, 0);
    check("rst_err_cnt", o_err_cnt, 0);

    // Directed cases
    frame(8'h82, 1, 8'd75, 8'd0, 8'd0, 8'd0);   // write LED2=75
    frame(8'h81, 1, 8'd40, 8'd0, 8'd0, 8'd0);   // write LED1=40
    frame(8'h01, 1, 8'h00, 8'd0, 8'd0, 8'd0);   // read LED1 -> 40, then 0
    frame(8'h83, 1, 8'd150, 8'd0, 8'd0, 8'd0);  // clamp to 100
    frame(8'h03, 1, 8'h00, 8'd0, 8'd0, 8'd0);   // read LED3 -> 100
    frame(8'h90, 1, 8'd33, 8'd0, 8'd0, 8'd0);   // reserved bit -> error
    frame(8'h80, 0, 8'd0, 8'd0, 8'd0, 8'd0);    // abort before data
    frame(8'h80, 1, 8'd5, 8'd0, 8'd0, 8'd0);    // next frame works
    frame(8'h83, 3, 8'd10, 8'd20, 8'd30, 8'd0); // burst wrap / single
    frame(8'h02, 3, 8'h00, 8'h00, 8'h00, 8'd0); // multi-byte read

    // Bytes outside a frame are ignored
    send_byte(8'h82);
    send_byte(8'd50);

    // Randomised frames
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 3));
      rc   = 8'($urandom_range(0, NUM_LEDS - 1));
      case (kind)
        0: rc[7] = 1'b1;
        1: rc[7] = 1'b0;
        2: rc = {1'($urandom), 5'($urandom_range(1, 31)), rc[1:0]};
        default: rc = {1'($urandom), 5'd0, rc[1:0]};
      endcase
      frame(rc, int'($urandom_range(0, 4) % 4), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom));
    end

    // Drive the error counter into saturation
    for (int n = 0; n < 256; n++) begin
      frame(8'h90 | 8'($urandom_range(0, 3)), 0, 8'd0, 8'd0, 8'd0, 8'd0);
    end
    check("err_cnt_saturated", o_err_cnt, 255);

    repeat (5) @(posedge sysclk);
    #1;
    check("pending_writes", wr_q.size(), 0);
    check("pending_tx", tx_q.size(), 0);
    check("pending_errs", err_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
